// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mips_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/MUX2to1.sv
// Generic two-input multiplexer: y = sel ? b : a, built bit by bit.
module MUX2to1 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N-1:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign y[gi] = sel ? b[gi] : a[gi];
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int N       = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [N-1:0]  if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [N-1:0]  dm_wdata,
  output logic [N-1:0]  dm_rdata,
  output logic          dm_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  input  logic          mem_ack,
  output logic          sel,
  output logic          err
);

  arb_state_t   state_reg, state_next;
  logic         sel_reg, sel_next;
  logic         prefer_dm_reg, prefer_dm_next;
  logic [N-1:0] if_rdata_reg, if_rdata_next;
  logic [N-1:0] dm_rdata_reg, dm_rdata_next;
  logic         timeout_hit;
  logic [N-1:0] capture_val;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;

  // Counter is held at zero outside BUSY so it restarts on every BUSY entry.
  always_comb begin
    cnt_next    = '0;
    timeout_hit = 1'b0;
    if (state_reg == ST_BUSY) begin
      cnt_next    = cnt_reg + 1'b1;
      timeout_hit = !mem_ack && (cnt_reg == CW'(TIMEOUT - 1));
    end
    err_next = err_reg | timeout_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // A timed-out access completes with zero data.
  assign capture_val = mem_ack ? mem_rdata : '0;

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    prefer_dm_next = prefer_dm_reg;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    if_ack         = 1'b0;
    dm_ack         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          state_next = ST_BUSY;
          if (dm_req && (!if_req || prefer_dm_reg)) begin
            sel_next       = SEL_DM;
            prefer_dm_next = 1'b0;
          end else begin
            sel_next       = SEL_IF;
            prefer_dm_next = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        mem_req = 1'b1;
        mem_we  = (sel_reg == SEL_DM) && dm_we;
        if (mem_ack || timeout_hit) begin
          state_next = ST_RESP;
          if (sel_reg == SEL_DM) dm_rdata_next = capture_val;
          else                   if_rdata_next = capture_val;
        end
      end
      ST_RESP: begin
        if_ack     = (sel_reg == SEL_IF);
        dm_ack     = (sel_reg == SEL_DM);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= SEL_IF;
      prefer_dm_reg <= 1'b1;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      prefer_dm_reg <= prefer_dm_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
    end
  end

  MUX2to1 #(.N(AW)) u_addr_mux (
    .a   (if_addr),
    .b   (dm_addr),
    .sel (sel_reg),
    .y   (mem_addr)
  );

  assign mem_wdata = dm_wdata;
  assign sel       = sel_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter; timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_ack, dm_ack;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        sel, err;
  logic        mem_en;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  mem_port_arbiter #(.N(32), .AW(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .sel       (sel),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: acks one cycle after it first sees mem_req.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack   <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      mem_ack   <= mem_en && mem_req && !mem_ack;
      mem_rdata <= mem_word(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge after requests are driven; follows one grant through to its ack.
  task automatic run_txn(input string tag, output int lat);
    exp_t e;
    int   cyc;
    logic sel_ok;
    e   = sb.pop_front();
    cyc = 0;
    while (mem_req !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " mem_req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, " sel"}, {31'b0, sel}, {31'b0, e.dm});
    chk({tag, " mem_addr"}, mem_addr, e.addr);
    chk({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, e.we});
    if (e.dm) chk({tag, " mem_wdata"}, mem_wdata, e.wdata);
    sel_ok = 1'b1;
    while (mem_req === 1'b1 && cyc < 80) begin
      if (sel !== e.dm) sel_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " sel_stable"}, {31'b0, sel_ok}, 32'd1);
    chk({tag, " own_ack"}, {31'b0, (e.dm ? dm_ack : if_ack)}, 32'd1);
    chk({tag, " other_ack"}, {31'b0, (e.dm ? if_ack : dm_ack)}, 32'd0);
    chk({tag, " rdata"}, (e.dm ? dm_rdata : if_rdata), e.rdata);
    $display("[TB] txn %s owner=%s addr=%h rdata=%h latency=%0d", tag, e.dm ? "DM" : "IF",
             e.addr, e.dm ? dm_rdata : if_rdata, cyc);
    lat = cyc;
    @(negedge clk);
  endtask

  initial begin
    int          lat;
    logic [31:0] last_if;
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_en = 1'b1;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    #1;
    chk("rst mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst if_ack", {31'b0, if_ack}, 32'd0);
    chk("rst dm_ack", {31'b0, dm_ack}, 32'd0);
    chk("rst sel", {31'b0, sel}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst dm_rdata", dm_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone fetch with single-cycle memory.
    if_addr = 32'h100; if_req = 1'b1;
    sb.push_back('{dm: 1'b0, we: 1'b0, addr: 32'h100, wdata: 32'h0, rdata: 32'hDEADBEEF});
    run_txn("if_lone", lat);
    chk("if_lone latency", lat, 32'd3);
    if_req = 1'b0;

    // Both held: grants alternate starting with data.
    if_addr = 32'h200; dm_addr = 32'h300; dm_wdata = 32'hCAFE0001; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        sb.push_back('{dm: 1'b1, we: 1'b0, addr: 32'h300, wdata: 32'hCAFE0001, rdata: mem_word(32'h300)});
      else
        sb.push_back('{dm: 1'b0, we: 1'b0, addr: 32'h200, wdata: 32'h0, rdata: mem_word(32'h200)});
    end
    for (int i = 0; i < 4; i++) run_txn($sformatf("rr%0d", i), lat);
    if_req = 1'b0; dm_req = 1'b0;
    last_if = mem_word(32'h200);
    @(negedge clk);

    // Data write.
    dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678; dm_req = 1'b1;
    sb.push_back('{dm: 1'b1, we: 1'b1, addr: 32'h40, wdata: 32'h12345678, rdata: mem_word(32'h40)});
    run_txn("dm_write", lat);
    dm_req = 1'b0; dm_we = 1'b0;
    chk("if_rdata hold", if_rdata, last_if);

    // Reset in the middle of a BUSY access.
    dm_addr = 32'h500; dm_req = 1'b1;
    @(negedge clk);
    chk("pre_rst mem_req", {31'b0, mem_req}, 32'd1);
    chk("pre_rst sel", {31'b0, sel}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst mem_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst sel", {31'b0, sel}, 32'd0);
    chk("mid_rst dm_ack", {31'b0, dm_ack}, 32'd0);
    dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst idle%0d", i), {30'b0, mem_req, dm_ack | if_ack}, 32'd0);
    end
    // Pointer returns to favouring data after reset.
    if_addr = 32'h600; dm_addr = 32'h700; if_req = 1'b1; dm_req = 1'b1;
    sb.push_back('{dm: 1'b1, we: 1'b0, addr: 32'h700, wdata: 32'h12345678, rdata: mem_word(32'h700)});
    run_txn("post_rst_rr", lat);
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    mem_en = 1'b0;
    if_addr = 32'h80; if_req = 1'b1;
    sb.push_back('{dm: 1'b0, we: 1'b0, addr: 32'h80, wdata: 32'h0, rdata: 32'h0});
    run_txn("timeout", lat);
    chk("timeout latency", lat, 32'd9);
    if_req = 1'b0;
    chk("timeout err", {31'b0, err}, 32'd1);
    mem_en = 1'b1;
    dm_addr = 32'h90; dm_req = 1'b1;
    sb.push_back('{dm: 1'b1, we: 1'b0, addr: 32'h90, wdata: 32'h12345678, rdata: mem_word(32'h90)});
    run_txn("after_timeout", lat);
    dm_req = 1'b0;
    chk("err sticky", {31'b0, err}, 32'd1);
    rst_n = 1'b0;
    #1 chk("err cleared", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    mem_en = 1'b0;
    dm_addr = 32'h80; dm_req = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_timeout mem_req", {31'b0, mem_req}, 32'd1);
    chk("no_timeout ack", {30'b0, dm_ack, if_ack}, 32'd0);
    chk("no_timeout err", {31'b0, err}, 32'd0);
    rst_n = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_en = 1'b1;
`endif
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter N, default 32, data width.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter TIMEOUT, default 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.
REQ-004 One clock, clk; reset rst_n is asynchronous, active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 if_req  in  1  instruction-fetch request; held until if_ack.
REQ-008 if_addr  in  AW  fetch address; stable while if_req.
REQ-009 if_rdata  out  N  fetched word, valid when if_ack.
REQ-010 if_ack  out  1  one-cycle fetch completion pulse.
REQ-011 dm_req  in  1  data-memory request; held until dm_ack.
REQ-012 dm_we  in  1  data write enable; stable while dm_req.
REQ-013 dm_addr  in  AW  data address; stable while dm_req.
REQ-014 dm_wdata  in  N  write data; stable while dm_req.
REQ-015 dm_rdata  out  N  read word, valid when dm_ack.
REQ-016 dm_ack  out  1  one-cycle data completion pulse.
REQ-017 mem_req  out  1  request to the shared memory port.
REQ-018 mem_we  out  1  write enable to memory; 0 for fetch.
REQ-019 mem_addr  out  AW  address steered from the granted requester.
REQ-020 mem_wdata  out  N  write data, equal to dm_wdata.
REQ-021 mem_rdata  in  N  memory read data, valid with mem_ack.
REQ-022 mem_ack  in  1  memory completion, single cycle.
REQ-023 sel  out  1  current owner: 0 = fetch, 1 = data.
REQ-024 err  out  1  sticky timeout flag.

Function
REQ-025 FSM states SHALL be IDLE, BUSY, RESP.
REQ-026 IDLE: transitions to BUSY when either request is high, latching the owner into sel.
REQ-027 Arbitration is round-robin: when both requests are high, the owner is the requester not granted most recently; after reset, data wins.
REQ-028 BUSY: mem_req=1, mem_addr/mem_we from the owner, with mem_we forced 0 when the owner is fetch; the FSM waits for mem_ack.
REQ-029 BUSY with mem_ack: mem_rdata is captured into the owner's rdata register, and the FSM transitions to RESP.
REQ-030 RESP: the owner's ack pulses for exactly one cycle, mem_req=0, and the FSM transitions to IDLE.
REQ-031 Latency: from request seen in IDLE to ack is (memory wait cycles + 2); the minimum is 3 cycles with a single-cycle memory.
REQ-032 sel is constant from IDLE exit until RESP exit; it never changes while mem_req=1.
REQ-033 A request arriving while BUSY or RESP is not lost; it is arbitrated at the next IDLE.
REQ-034 mem_ack outside BUSY is ignored.
REQ-035 if_rdata/dm_rdata hold their last captured values until the next capture for that requester.

Reset
REQ-036 On rst_n low, the block SHALL enter IDLE immediately: mem_req=0, if_ack=0, dm_ack=0, sel=0, err=0, rdata registers 0, round-robin pointer favouring data.
REQ-037 Reset mid-transaction abandons the transaction with no ack; the requester re-issues it.

Configuration
REQ-038 Macro ARB_TIMEOUT_EN defined: a counter starts at BUSY entry. If it reaches TIMEOUT without mem_ack, the owner's ack pulses with rdata=0, err is set sticky, and the FSM transitions to IDLE via RESP.
REQ-039 Macro undefined: no counter; BUSY waits indefinitely; err is tied 0.

Structure
REQ-040 Package mips_arb_pkg SHALL hold the state enum typedef, the SEL_IF=0/SEL_DM=1 constants and the default TIMEOUT.
REQ-041 Address steering SHALL instantiate the existing MUX2to1 (N=AW) with sel as its select; no other sub-module.

Verification
REQ-042 The bench SHALL cover:
- Lone if_req, addr 0x100, memory acks after 1 cycle with 0xDEADBEEF -> mem_we=0, if_ack at cycle 3, if_rdata=0xDEADBEEF, dm_ack never asserted.
- Both requests held for 4 transactions -> grants alternate DM, IF, DM, IF; sel is stable during each mem_req.
- dm_we=1, addr 0x40, wdata 0x12345678 -> mem_we=1, mem_addr=0x40, mem_wdata=0x12345678, dm_ack after mem_ack.
- rst_n low during BUSY -> mem_req=0 immediately, no ack, FSM in IDLE, sel=0.
- ARB_TIMEOUT_EN with TIMEOUT=8 and mem_ack never asserted -> ack pulses, rdata=0 and err=1 after 8 BUSY cycles; err stays set until reset.
